alu_apb_regs: RTL and testbench
===============================

# alu_apb_regs

APB3 responder that fronts the ALU datapath: decodes APB write/read transfers from the bus initiator into operand, control and status registers, launches ALU operations, and returns results through `prdata`. Simple operations take one execute cycle; multiply is a 32-cycle shift-add sequence. Wait states (`pready` low) protect operand, control and result registers while an operation is in flight. Sits between the APB initiator (the testbench or system interconnect) and the ALU core.

## Interface
- `BASE_ADDR`, 32'h0000_0000, block base; `paddr[31:5]` must equal `BASE_ADDR[31:5]`, else `pslverr`.
- `clk`  input  1  clock, all state on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `psel`  input  1  APB select.
- `penable`  input  1  APB access phase.
- `pwrite`  input  1  1 = write, 0 = read.
- `paddr`  input  32  byte address.
- `pwdata`  input  32  write data.
- `prdata`  output  32  read data, valid only when `psel & penable & pready & !pwrite`; 0 otherwise.
- `pready`  output  1  transfer completes on the rising edge where `psel & penable & pready`.
- `pslverr`  output  1  error response, meaningful only with `pready`; 0 otherwise.

## Operation
- Registers (offset from base): 0x00 CTRL (RW: [0] START, self-clearing, reads 0; [4:1] OPCODE); 0x04 OPA (RW); 0x08 OPB (RW); 0x0C RESULT (RO); 0x10 STATUS ([0] BUSY RO, [1] DONE W1C, [2] OVF W1C, [3] ILL W1C).
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL (A << B[4:0]), 6 SHR logical (A >> B[4:0]), 7 MUL (unsigned, low 32 bits). 8–15 illegal.
- OVF: ADD/SUB signed two's-complement overflow; MUL high 32 bits nonzero; 0 for other ops.
- Illegal opcode: RESULT=0, ILL=1, OVF=0, DONE=1, one execute cycle.
- Executor FSM: IDLE -> EXEC on accepted CTRL write with START=1; EXEC -> IDLE after 1 cycle (opcodes 0–6, 8–15) or 32 cycles (MUL, counter 31..0); on exit RESULT, OVF/ILL, DONE=1 update, BUSY=0. OPCODE is sampled into the FSM on START.
- CTRL write with START=0 only updates OPCODE.
- Error (`pslverr=1`, zero wait): `paddr[1:0]!=0`, offset >0x10, base mismatch, write to RESULT. No register changes; `prdata=0`.
- Writes to STATUS bit 0 ignored; W1C bits clear only where `pwdata` bit is 1.

## Timing
- Reset: all registers 0, FSM IDLE, `prdata=0`, `pready=0` outside access phase, `pslverr=0`. Reset mid-EXEC aborts; no DONE.
- `pready` is combinational: 1 in access phase unless stalled. Stall while BUSY for writes to CTRL/OPA/OPB and reads of RESULT; released in the cycle after the FSM returns to IDLE. STATUS/OPA/OPB/CTRL reads and STATUS writes never stall.
- Setup phase (`psel & !penable`): no side effects.
- START accepted at edge T: BUSY=1 after T; simple op: RESULT/DONE valid and BUSY=0 after T+1; MUL: after T+32.
- DONE/OVF/ILL set by completion and W1C clear on same edge: set wins.
- `psel` dropped mid-stall: transfer abandoned, no write.

## Test plan
- Reset, read all 5 registers -> 0, `pslverr=0`, zero wait states.
- OPA=0x7FFF_FFFF, OPB=1, CTRL=0x01 (ADD, START) -> RESULT 0x8000_0000, STATUS=0x6 two cycles after START edge.
- OPA=0x0001_0000, OPB=0x0001_0000, CTRL=0x0F (MUL) -> BUSY for 32 cycles; immediate RESULT read stalls until done, returns 0x0000_0000, OVF=1; OPA write during BUSY stalls, then lands.
- CTRL=0x11 (opcode 8) -> RESULT 0, STATUS=0xA; write STATUS=0x8 -> STATUS=0x2.
- Read 0x06, write 0x0C, read 0x14 -> `pready=1`, `pslverr=1`, `prdata=0`, registers unchanged.
- Assert `reset_n` low at MUL cycle 10 -> all registers 0, BUSY=0, DONE=0; next ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_apb_regs.sv
// rtl/alu_apb_regs.sv - APB3 register front end with a one-cycle ALU and a 32-cycle shift-add multiplier
module alu_apb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_OPA    = 5'h04;
    localparam logic [4:0] OFF_OPB    = 5'h08;
    localparam logic [4:0] OFF_RESULT = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [3:0] OP_MUL     = 4'd7;

    typedef enum logic [0:0] {IDLE, EXEC} state_t;

    state_t      state_q, state_d;
    logic [3:0]  opcode;
    logic [3:0]  exec_op;
    logic [31:0] opa, opb, result;
    logic        done, ovf, ill;
    logic [4:0]  cnt;
    logic [63:0] prod;

    logic [4:0]  offset;
    logic        access, busy, addr_err, err, stall;
    logic        wr_en, rd_en, start, sts_wr, finish;
    logic [31:0] rdata;

    assign offset   = paddr[4:0];
    assign access   = psel & penable;
    assign busy     = (state_q == EXEC);
    assign addr_err = (paddr[1:0] != 2'b00) || (offset > OFF_STATUS) ||
                      (paddr[31:5] != BASE_ADDR[31:5]);
    assign err      = addr_err || (pwrite && offset == OFF_RESULT);

    // Errored transfers never wait, so the stall check only covers legal addresses.
    assign stall    = busy && !err &&
                      (pwrite ? (offset == OFF_CTRL || offset == OFF_OPA || offset == OFF_OPB)
                              : (offset == OFF_RESULT));

    assign pready   = access && !stall;
    assign pslverr  = access && err;
    assign wr_en    = access && pwrite && !stall && !err;
    assign rd_en    = access && !pwrite && !stall && !err;
    assign start    = wr_en && (offset == OFF_CTRL) && pwdata[0];
    assign sts_wr   = wr_en && (offset == OFF_STATUS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (exec_op != OP_MUL || cnt == 5'd0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [31:0] sum, diff, alu_res;
    logic [32:0] mul_upper;
    logic [63:0] prod_next;
    logic        alu_ovf, alu_ill;

    assign sum       = opa + opb;
    assign diff      = opa - opb;
    // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
    assign mul_upper = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opa} : 33'd0);
    assign prod_next = {mul_upper, prod[31:1]};

    always_comb begin
        alu_res = 32'd0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (exec_op)
            4'd0: begin
                alu_res = sum;
                alu_ovf = (opa[31] == opb[31]) && (sum[31] != opa[31]);
            end
            4'd1: begin
                alu_res = diff;
                alu_ovf = (opa[31] != opb[31]) && (diff[31] != opa[31]);
            end
            4'd2: alu_res = opa & opb;
            4'd3: alu_res = opa | opb;
            4'd4: alu_res = opa ^ opb;
            4'd5: alu_res = opa << opb[4:0];
            4'd6: alu_res = opa >> opb[4:0];
            4'd7: begin
                alu_res = prod_next[31:0];
                alu_ovf = |prod_next[63:32];
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode  <= 4'd0;
            exec_op <= 4'd0;
            opa     <= 32'd0;
            opb     <= 32'd0;
            result  <= 32'd0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            ill     <= 1'b0;
            cnt     <= 5'd0;
            prod    <= 64'd0;
        end else begin
            if (wr_en && offset == OFF_CTRL) opcode <= pwdata[4:1];
            if (wr_en && offset == OFF_OPA)  opa    <= pwdata;
            if (wr_en && offset == OFF_OPB)  opb    <= pwdata;

            if (start) begin
                exec_op <= pwdata[4:1];
                cnt     <= 5'd31;
                prod    <= {32'd0, opb};
            end else if (busy && !finish) begin
                cnt     <= cnt - 5'd1;
                prod    <= prod_next;
            end

            if (finish) result <= alu_res;

            // Completion overrides a simultaneous write-one-to-clear.
            done <= finish | (done & ~(sts_wr & pwdata[1]));
            ovf  <= finish ? alu_ovf : (ovf & ~(sts_wr & pwdata[2]));
            ill  <= finish ? alu_ill : (ill & ~(sts_wr & pwdata[3]));
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (offset)
            OFF_CTRL:   rdata = {27'd0, opcode, 1'b0};
            OFF_OPA:    rdata = opa;
            OFF_OPB:    rdata = opb;
            OFF_RESULT: rdata = result;
            OFF_STATUS: rdata = {28'd0, ill, ovf, done, busy};
            default:    rdata = 32'd0;
        endcase
    end

    assign prdata = rd_en ? rdata : 32'd0;

endmodule

// File: tb/tb_alu_apb_regs.sv
// tb/tb_alu_apb_regs.sv - directed APB bench for alu_apb_regs with hand-computed expectations
module tb_alu_apb_regs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_OPA    = 32'h04;
    localparam logic [31:0] A_OPB    = 32'h08;
    localparam logic [31:0] A_RESULT = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;

    int n_tests = 0;
    int n_fail  = 0;

    alu_apb_regs #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic err, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!pready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        check("pready", {31'd0, pready}, 32'd1);
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_xfer(1'b1, addr, data, d, e, w);
        check($sformatf("wr_err@%02h", addr[7:0]), {31'd0, e}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_xfer(1'b0, addr, 32'd0, d, e, w);
        check(tag, d, exp);
        check({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        v;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          w;

        vecs[0] = '{4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[1] = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[2] = '{4'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
        vecs[3] = '{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        vecs[4] = '{4'd5, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0};
        vecs[5] = '{4'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
        vecs[6] = '{4'd7, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b0, 32'(i * 4), 32'd0, d, e, w);
            check($sformatf("rst_data%0d", i), d, 32'd0);
            check($sformatf("rst_err%0d", i), {31'd0, e}, 32'd0);
            check($sformatf("rst_wait%0d", i), 32'(w), 32'd0);
        end

        wr(A_OPA, 32'h7FFF_FFFF);
        wr(A_OPB, 32'h0000_0001);
        wr(A_CTRL, 32'h0000_0001);
        rd("add_result", A_RESULT, 32'h8000_0000);
        rd("add_status", A_STATUS, 32'h0000_0006);

        wr(A_OPA, 32'h0001_0000);
        wr(A_OPB, 32'h0001_0000);
        wr(A_CTRL, 32'h0000_000F);
        rd("mul_busy_status", A_STATUS, 32'h0000_0007);
        apb_xfer(1'b0, A_RESULT, 32'd0, d, e, w);
        check("mul_result", d, 32'h0000_0000);
        check("mul_result_waits", 32'(w), 32'd27);
        rd("mul_status", A_STATUS, 32'h0000_0006);

        wr(A_OPA, 32'h0000_1234);
        wr(A_OPB, 32'h0000_0010);
        wr(A_CTRL, 32'h0000_000F);
        apb_xfer(1'b1, A_OPA, 32'h0000_CAFE, d, e, w);
        check("opa_busy_waits", 32'(w), 32'd30);
        check("opa_busy_err", {31'd0, e}, 32'd0);
        rd("mul2_result", A_RESULT, 32'h0001_2340);
        rd("mul2_status", A_STATUS, 32'h0000_0002);
        rd("opa_landed", A_OPA, 32'h0000_CAFE);

        foreach (vecs[i]) begin
            wr(A_OPA, vecs[i].a);
            wr(A_OPB, vecs[i].b);
            wr(A_CTRL, {27'd0, vecs[i].op, 1'b1});
            rd($sformatf("vec%0d_result", i), A_RESULT, vecs[i].r);
            rd($sformatf("vec%0d_status", i), A_STATUS, vecs[i].v ? 32'h6 : 32'h2);
        end

        wr(A_CTRL, 32'h0000_0011);
        rd("ill_result", A_RESULT, 32'h0000_0000);
        rd("ill_status", A_STATUS, 32'h0000_000A);
        rd("ill_ctrl", A_CTRL, 32'h0000_0010);
        wr(A_STATUS, 32'h0000_0008);
        rd("w1c_ill", A_STATUS, 32'h0000_0002);
        wr(A_STATUS, 32'h0000_0007);
        rd("w1c_all", A_STATUS, 32'h0000_0000);

        apb_xfer(1'b0, 32'h06, 32'd0, d, e, w);
        check("err06_slverr", {31'd0, e}, 32'd1);
        check("err06_data", d, 32'd0);
        check("err06_waits", 32'(w), 32'd0);
        apb_xfer(1'b1, A_RESULT, 32'h0000_0055, d, e, w);
        check("err0c_slverr", {31'd0, e}, 32'd1);
        check("err0c_waits", 32'(w), 32'd0);
        apb_xfer(1'b0, 32'h14, 32'd0, d, e, w);
        check("err14_slverr", {31'd0, e}, 32'd1);
        check("err14_data", d, 32'd0);
        apb_xfer(1'b1, 32'h104, 32'h0000_0099, d, e, w);
        check("errbase_slverr", {31'd0, e}, 32'd1);
        rd("err_opa_kept", A_OPA, 32'hFFFF_FFFF);
        rd("err_result_kept", A_RESULT, 32'h0000_0000);

        wr(A_OPA, 32'h0000_0005);
        wr(A_OPB, 32'h0000_0006);
        wr(A_CTRL, 32'h0000_000F);
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd($sformatf("abort_reg%0d", i), 32'(i * 4), 32'd0);
        end

        wr(A_OPA, 32'h0000_0003);
        wr(A_OPB, 32'h0000_0004);
        wr(A_CTRL, 32'h0000_0001);
        rd("post_reset_add", A_RESULT, 32'h0000_0007);
        rd("post_reset_status", A_STATUS, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
